// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller (master) and decoder_scan_sequencer (slave).
// Optional `down` signal exists only when DECODER_SCAN_SEQUENCER_DOWN_EN is defined.
interface decoder_scan_sequencer_if #(
    parameter int unsigned IN      = 9,
    parameter int unsigned DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic [IN-1:0]      first_addr;
    logic [IN-1:0]      last_addr;
    logic [DWELL_W-1:0] dwell;
    logic               continuous;
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
    logic               down;
`endif
    logic [IN-1:0]      binary_out;
    logic               enable_out;
    logic               busy;
    logic               done;
    logic               wrap;

    modport master (
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
        output down,
`endif
        output start, stop, first_addr, last_addr, dwell, continuous,
        input  binary_out, enable_out, busy, done, wrap
    );

    modport slave (
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
        input  down,
`endif
        input  start, stop, first_addr, last_addr, dwell, continuous,
        output binary_out, enable_out, busy, done, wrap
    );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Sweeps a decoder select index from first to last with a programmable dwell; one-shot or continuous.
// Define DECODER_SCAN_SEQUENCER_DOWN_EN to add a latched `down` input that steps the index downward.
module decoder_scan_sequencer #(
    parameter int unsigned IN      = 9,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_scan_sequencer_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Sweep configuration captured on an accepted start
    typedef struct packed {
        logic [IN-1:0]      first;
        logic [IN-1:0]      last;
        logic [DWELL_W-1:0] dwell;
        logic               continuous;
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
        logic               down;
`endif
    } cfg_t;

    state_t             state;
    cfg_t               cfg;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [IN-1:0]      index_q;
    logic               enable_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;
    logic [IN-1:0]      next_index_c;
    logic               expiry_c;

    // Neighbouring index, modulo 2^IN through natural overflow
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
    assign next_index_c = cfg.down ? (index_q - IN'(1)) : (index_q + IN'(1));
`else
    assign next_index_c = index_q + IN'(1);
`endif

    assign expiry_c = (dwell_cnt == cfg.dwell);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg       <= '0;
            dwell_cnt <= '0;
            index_q   <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        cfg.first      <= bus.first_addr;
                        cfg.last       <= bus.last_addr;
                        cfg.dwell      <= bus.dwell;
                        cfg.continuous <= bus.continuous;
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
                        cfg.down       <= bus.down;
`endif
                        index_q   <= bus.first_addr;
                        enable_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        dwell_cnt <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Abort overrides any expiry action and suppresses done/wrap
                    if (bus.stop) begin
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else if (expiry_c) begin
                        dwell_cnt <= '0;
                        if (index_q != cfg.last) begin
                            index_q <= next_index_c;
                        end else if (cfg.continuous) begin
                            index_q <= cfg.first;
                            wrap_q  <= 1'b1;
                        end else begin
                            enable_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.binary_out = index_q;
    assign bus.enable_out = enable_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed plus randomized sweeps checked against an index-arithmetic reference model.
module tb_decoder_scan_sequencer;

    localparam int unsigned IN      = 9;
    localparam int unsigned DWELL_W = 8;
    localparam int          SPAN    = 1 << IN;

    logic clk;
    logic rst_n;

    decoder_scan_sequencer_if #(.IN(IN), .DWELL_W(DWELL_W)) bus ();

    decoder_scan_sequencer #(.IN(IN), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference model state for the sweep in progress
    int m_first, m_last, m_k, m_p, m_end_bo;
    bit m_cont;
    logic       exp_en, exp_busy, exp_done, exp_wrap;
    logic [8:0] exp_bo;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bo"},   32'(bus.binary_out), 32'(exp_bo));
        chk({tag, "_en"},   32'(bus.enable_out), 32'(exp_en));
        chk({tag, "_busy"}, 32'(bus.busy),       32'(exp_busy));
        chk({tag, "_done"}, 32'(bus.done),       32'(exp_done));
        chk({tag, "_wrap"}, 32'(bus.wrap),       32'(exp_wrap));
    endtask

    task automatic idle_check(input string tag, input int bo);
        exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_wrap = 1'b0;
        exp_bo = 9'(bo);
        check_all(tag);
    endtask

    // Expected outputs t cycles after the sweep's first enabled cycle
    task automatic model_at(input int t);
        if (!m_cont && t == m_k * m_p) begin
            exp_en = 1'b0; exp_busy = 1'b0; exp_done = 1'b1; exp_wrap = 1'b0;
            exp_bo = 9'(m_last);
        end else begin
            exp_en = 1'b1; exp_busy = 1'b1; exp_done = 1'b0;
            exp_wrap = m_cont && t > 0 && (t % (m_k * m_p)) == 0;
            exp_bo = 9'((m_first + (t / m_p) % m_k) % SPAN);
        end
    endtask

    // Start a sweep, follow it cycle by cycle while scrambling the run-time-ignored inputs.
    // Returns in the done cycle (one-shot) or one cycle after stop.
    task automatic run(input int f, input int l, input int d, input bit cont,
                       input int stop_at, input string tag);
        m_first = f; m_last = l; m_cont = cont; m_p = d + 1;
        m_k = ((l - f) % SPAN + SPAN) % SPAN + 1;
        bus.first_addr = 9'(f);
        bus.last_addr  = 9'(l);
        bus.dwell      = 8'(d);
        bus.continuous = cont;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t <= 2000; t++) begin
            model_at(t);
            check_all(tag);
            if (t == stop_at) begin
                m_end_bo = int'(exp_bo);
                bus.stop = 1'b1;
                tick();
                bus.stop = 1'b0;
                idle_check({tag, "_stop"}, m_end_bo);
                return;
            end
            if (!cont && t == m_k * m_p) begin
                m_end_bo = l;
                return;
            end
            bus.first_addr = 9'($urandom);
            bus.last_addr  = 9'($urandom);
            bus.dwell      = 8'($urandom);
            bus.continuous = 1'($urandom);
            bus.start      = 1'($urandom);
            tick();
            bus.start = 1'b0;
        end
        chk({tag, "_bound"}, 32'd0, 32'd1);
    endtask

    initial begin
        int f, l, d, sa;
        bit c;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.first_addr = '0;
        bus.last_addr = '0;
        bus.dwell = '0;
        bus.continuous = 1'b0;
`ifdef DECODER_SCAN_SEQUENCER_DOWN_EN
        bus.down = 1'b0;
`endif
        tick();
        tick();
        idle_check("in_reset", 0);
        rst_n = 1'b1;
        tick();
        idle_check("reset", 0);

        // start and stop together in IDLE are ignored
        bus.first_addr = 9'd7;
        bus.last_addr = 9'd9;
        bus.start = 1'b1;
        bus.stop = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        idle_check("start_stop", 0);
        tick();
        idle_check("start_stop2", 0);

        run(3, 6, 0, 1'b0, -1, "t1");
        // next start lands in the done cycle: exactly one low enable cycle
        run(510, 1, 1, 1'b0, -1, "t2");
        tick();
        idle_check("t2_idle", 1);

        // stop on the expiry cycle at last index: no reload, no wrap
        run(2, 4, 2, 1'b1, 17, "t3");
        tick();
        idle_check("t3_idle", 4);

        // asynchronous reset mid-sweep
        bus.first_addr = 9'd100;
        bus.last_addr = 9'd120;
        bus.dwell = 8'd0;
        bus.continuous = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        idle_check("async_rst", 0);
        #3 rst_n = 1'b1;
        tick();
        idle_check("post_rst", 0);
        tick();
        idle_check("post_rst2", 0);

        // randomized sweeps
        for (int i = 0; i < 10; i++) begin
            f = int'($urandom_range(0, SPAN - 1));
            l = (f + int'($urandom_range(0, 5))) % SPAN;
            d = int'($urandom_range(0, 3));
            c = 1'($urandom);
            m_k = ((l - f) % SPAN + SPAN) % SPAN + 1;
            if (c) sa = int'($urandom_range(0, 40));
            else if ($urandom_range(0, 2) == 0) sa = int'($urandom_range(0, m_k * (d + 1) - 1));
            else sa = -1;
            run(f, l, d, c, sa, $sformatf("rnd%0d", i));
            tick();
            idle_check($sformatf("rnd%0d_idle", i), m_end_bo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream stage of the N-to-one-hot binary decoder; drives its `binary_in` and `enable` inputs.
- Sweeps a binary select index from a programmable first address to a last address, holding each index for a programmable dwell time.
- Supports one-shot or continuous sweep, with start/stop control and done/wrap status pulses.
- Used to scan one-hot select lines, such as the test-point or cell-enable arrays, without CPU involvement.

Parameters:
- IN, 9, index width; must equal the downstream decoder's IN.
- DWELL_W, 8, width of the dwell-count field.

Ports:
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  sweep request pulse; sampled only in IDLE.
- stop  input  1  abort request; sampled in RUN; takes priority over start in IDLE.
- first_addr  input  IN  sweep start index; latched on accepted start.
- last_addr  input  IN  sweep end index; latched on accepted start.
- dwell  input  DWELL_W  cycles per index minus 1; latched on accepted start.
- continuous  input  1  1 = wrap to first_addr forever; 0 = one-shot; latched on accepted start.
- binary_out  output  IN  registered index, drives decoder binary_in.
- enable_out  output  1  registered enable, drives decoder enable.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on natural one-shot completion.
- wrap  output  1  one-cycle pulse when a continuous sweep reloads first_addr.

Behaviour:
- Single clock `clk`.
- Reset is asynchronous and active-low on `rst_n`: assertion immediately forces all outputs and internal registers to 0 and the state to IDLE, including mid-sweep. No output glitches high during reset.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, RUN.
- IDLE:
  - enable_out = 0; busy = 0; binary_out holds its last value (0 after reset).
  - start=1 and stop=0: latch first_addr, last_addr, dwell and continuous. Next cycle: binary_out = first_addr, enable_out = 1, busy = 1, dwell counter = 0, state RUN.
  - start=1 and stop=1 in the same cycle: ignored, remain IDLE.
- RUN:
  - Dwell counter increments each cycle. Each index is held for dwell+1 cycles; dwell=0 gives one cycle per index.
  - Dwell expiry with binary_out != last_latched: binary_out <= binary_out + 1, modulo 2^IN. If first > last, the sweep wraps through 2^IN-1 to 0 before reaching last. Counter resets to 0.
  - Dwell expiry with binary_out == last_latched and continuous latched = 1: binary_out <= first_latched; wrap = 1 for exactly that one cycle (coincident with the reload); stay in RUN.
  - Dwell expiry with binary_out == last_latched and continuous latched = 0: next cycle enable_out = 0, busy = 0, done = 1 for one cycle; go to IDLE. binary_out keeps last_latched.
  - first == last: a single index is held for dwell+1 cycles, then done (one-shot) or wrap every dwell+1 cycles (continuous).
  - stop=1 in any RUN cycle, including a dwell-expiry cycle: next cycle enable_out = 0, busy = 0, go to IDLE. done and wrap are NOT asserted. stop wins over any simultaneous expiry action.
  - start while in RUN is ignored. Changes to first_addr, last_addr, dwell or continuous during RUN have no effect.
- Latency:
  - start to first enable_out: 1 cycle.
  - Total one-shot sweep of K indices: K*(dwell+1) cycles of enable_out high, then done in the following cycle.
- Back-to-back: start may be accepted in the same cycle that done is high, since the state is already IDLE. enable_out then re-asserts the next cycle, giving exactly one low cycle.

Optional Feature:
- Macro: DECODER_SCAN_SEQUENCER_DOWN_EN.
- Defined:
  - Adds input port `down` (1 bit), latched on accepted start.
  - down=1: index steps binary_out - 1 modulo 2^IN from first toward last; wrap and done rules unchanged.
  - down=0: behaves as the up-counting design.
- Undefined: `down` port absent; always counts up.

Test Plan:
- first=3, last=6, dwell=0, continuous=0, start pulse -> binary_out 3,4,5,6 on four consecutive cycles with enable_out=1; done=1 on the 5th cycle with enable_out=0; binary_out stays 6.
- first=510, last=1, dwell=1, IN=9 -> indices 510,511,0,1, each held 2 cycles (8 enable cycles), then done.
- first=2, last=4, dwell=2, continuous=1 -> sequence 2,2,2,3,3,3,4,4,4,2...; wrap pulses on each reload to 2; done never asserted.
- Running sweep, stop asserted on a dwell-expiry cycle at index == last with continuous=1 -> next cycle enable_out=0, busy=0, no wrap, no done; binary_out not reloaded.
- rst_n driven low mid-sweep, asynchronously between clock edges -> enable_out, busy and binary_out go to 0 immediately; after release the block sits in IDLE until start.
- start and stop both high in IDLE -> no state change. start accepted in the cycle done is high -> exactly one cycle of enable_out=0 between the two sweeps.
